// File: rtl/spi_master_fifo.sv
// rtl/spi_master_fifo.sv - memory-mapped SPI master with TX/RX FIFOs, SS hold and RX interrupt
module spi_master_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_SS     = 2,
   parameter int DIV_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       d_in,
   input  logic              cs,
   input  logic [3:0]        addr,
   input  logic              rd,
   input  logic              wr,
   output logic [15:0]       d_out,
   output logic              irq,
   input  logic              miso,
   output logic              mosi,
   output logic              sck,
   output logic [NUM_SS-1:0] ss
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(2 * DATA_W + 1);
   localparam logic [TW-1:0] LAST_TOG = TW'(2 * DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, TAIL} state_t;
   state_t state, state_nxt;

   logic              en, cpol, cpha, hold, ie;
   logic [2:0]        ss_sel;
   logic [DIV_W-1:0]  div;
   logic              tx_ovf, rx_ovf;

   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [AW:0]       tx_wp, tx_rp, rx_wp, rx_rp;

   logic              l_cpha;
   logic [DIV_W-1:0]  l_div, hp_cnt;
   logic [TW-1:0]     tog_cnt;
   logic [DATA_W-1:0] tx_sr, rx_sr;

   logic bus_wr, bus_rd, clr_flags;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_req, tx_push, tx_pop, rx_push, rx_pop;
   logic tick, load, toggle, finish, leading, last;
   logic [DATA_W-1:0] tx_head, rx_head;
   logic [15:0] rd_data;
   logic unused_d_in;

   assign bus_wr    = cs && wr;
   assign bus_rd    = cs && rd;
   assign clr_flags = bus_wr && (addr == 4'h2) && d_in[8];
   assign unused_d_in = ^d_in;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign tx_head  = tx_mem[tx_rp[AW-1:0]];
   assign rx_head  = rx_mem[rx_rp[AW-1:0]];

   // A full FIFO still accepts a push when the same edge pops a slot.
   assign tx_req  = bus_wr && (addr == 4'h0);
   assign tx_pop  = load;
   assign tx_push = tx_req && (!tx_full || tx_pop);
   assign rx_pop  = bus_rd && (addr == 4'h4) && !rx_empty;
   assign rx_push = finish && (!rx_full || rx_pop);

   assign tick    = (hp_cnt == l_div);
   assign leading = !tog_cnt[0];
   assign last    = (tog_cnt == LAST_TOG);

   function automatic logic [NUM_SS-1:0] ss_decode(input logic [2:0] sel);
      ss_decode = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (sel == 3'(i)) ss_decode[i] = 1'b0;
   endfunction

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      toggle    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: if (en && !tx_empty) begin
            load      = 1'b1;
            state_nxt = SETUP;
         end
         SETUP: if (tick) state_nxt = SHIFT;
         SHIFT: if (tick) begin
            toggle = 1'b1;
            if (last) state_nxt = TAIL;
         end
         TAIL: if (tick) begin
            finish = 1'b1;
            if (hold && en && !tx_empty) begin
               load      = 1'b1;
               state_nxt = SETUP;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck     <= 1'b0;
         mosi    <= 1'b0;
         ss      <= '1;
         l_cpha  <= 1'b0;
         l_div   <= '0;
         hp_cnt  <= '0;
         tog_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
      end else begin
         if (load || state == IDLE || tick) hp_cnt <= '0;
         else                                hp_cnt <= hp_cnt + DIV_W'(1);

         if (load) begin
            // Mode, divider and slave are frozen per word; mid-word CTRL/DIV writes wait.
            sck     <= cpol;
            ss      <= ss_decode(ss_sel);
            l_cpha  <= cpha;
            l_div   <= div;
            tog_cnt <= '0;
            tx_sr   <= tx_head;
            if (!cpha) mosi <= tx_head[DATA_W-1];
         end else begin
            if (finish) ss <= '1;
            if (state == IDLE) sck <= cpol;
            if (toggle) begin
               sck     <= ~sck;
               tog_cnt <= tog_cnt + TW'(1);
               if (l_cpha ? leading : (!leading && !last)) begin
                  mosi  <= l_cpha ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
                  tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
               end
               if (l_cpha ? !leading : leading)
                  rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         4'h2: rd_data[7:0] = {ss_sel, ie, hold, cpha, cpol, en};
         4'h4: if (!rx_empty) rd_data[DATA_W-1:0] = rx_head;
         4'h6: rd_data[6:0] = {rx_ovf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty, state != IDLE};
         4'h8: rd_data[DIV_W-1:0] = div;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {en, cpol, cpha, hold, ie} <= '0;
         ss_sel <= '0;
         div    <= '0;
         tx_ovf <= 1'b0;
         rx_ovf <= 1'b0;
         tx_wp  <= '0;
         tx_rp  <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         d_out  <= '0;
         irq    <= 1'b0;
      end else begin
         if (bus_wr && addr == 4'h2) begin
            en     <= d_in[0];
            cpol   <= d_in[1];
            cpha   <= d_in[2];
            hold   <= d_in[3];
            ie     <= d_in[4];
            ss_sel <= d_in[7:5];
         end
         if (bus_wr && addr == 4'h8) div <= d_in[DIV_W-1:0];
         tx_ovf <= (tx_ovf && !clr_flags) || (tx_req && !tx_push);
         rx_ovf <= (rx_ovf && !clr_flags) || (finish && !rx_push);
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         if (bus_rd)  d_out <= rd_data;
         irq <= ie && !rx_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= d_in[DATA_W-1:0];
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sr;
   end
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb/tb_spi_master_fifo.sv - directed self-checking bench for spi_master_fifo
module tb_spi_master_fifo;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] d_in;
   logic        cs, rd, wr;
   logic [3:0]  addr;
   wire  [15:0] d_out;
   wire         irq, mosi, sck;
   wire  [1:0]  ss;
   logic        loop_en;
   logic        slave_miso;
   wire         miso_w = loop_en ? mosi : slave_miso;

   logic       tb_cpol, tb_cpha;
   logic [7:0] slave_word, slv_out, slv_rx;

   int total = 0;
   int bad   = 0;

   spi_master_fifo dut (
      .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
      .d_out(d_out), .irq(irq), .miso(miso_w), .mosi(mosi), .sck(sck), .ss(ss)
   );

   always #5 clk = ~clk;

   // SPI slave on ss[0]: shifts out slave_word MSB first, captures mosi
   always @(negedge ss[0]) begin
      slv_out = slave_word;
      slv_rx  = 8'h00;
      if (!tb_cpha) begin
         slave_miso = slv_out[7];
         slv_out    = {slv_out[6:0], 1'b0};
      end
   end

   always @(sck) begin
      if (ss[0] === 1'b0) begin
         if ((sck !== tb_cpol) ^ tb_cpha) begin
            slv_rx = {slv_rx[6:0], mosi};
         end else begin
            slave_miso = slv_out[7];
            slv_out    = {slv_out[6:0], 1'b0};
         end
      end
   end

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      d = d_out;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      #2 rst = 1'b0;
      #1;
      total++; if (sck !== 1'b0)    begin bad++; $display("FAIL por_sck got=%b exp=0", sck); end
      total++; if (ss !== 2'b11)    begin bad++; $display("FAIL por_ss got=%b exp=11", ss); end
      total++; if (d_out !== 16'h0) begin bad++; $display("FAIL por_dout got=%h exp=0000", d_out); end
      total++; if (irq !== 1'b0)    begin bad++; $display("FAIL por_irq got=%b exp=0", irq); end
      @(negedge clk) rst = 1'b1;
      bus_write(4'h8, 16'd3);
      bus_write(4'h2, 16'h0003);
      bus_write(4'h0, 16'h00F0);
      repeat (10) @(negedge clk);
      bus_read(4'h6, v);
      total++; if (v !== 16'h000B) begin bad++; $display("FAIL busy_status got=%h exp=000b", v); end
      total++; if (ss !== 2'b10)   begin bad++; $display("FAIL busy_ss got=%b exp=10", ss); end
      #3 rst = 1'b0;
      #1;
      total++; if (sck !== 1'b0)    begin bad++; $display("FAIL rst_sck got=%b exp=0", sck); end
      total++; if (ss !== 2'b11)    begin bad++; $display("FAIL rst_ss got=%b exp=11", ss); end
      total++; if (d_out !== 16'h0) begin bad++; $display("FAIL rst_dout got=%h exp=0000", d_out); end
      total++; if (mosi !== 1'b0)   begin bad++; $display("FAIL rst_mosi got=%b exp=0", mosi); end
      @(negedge clk) rst = 1'b1;
      bus_read(4'h6, v);
      total++; if (v !== 16'h000A) begin bad++; $display("FAIL rst_status got=%h exp=000a", v); end
      bus_read(4'h2, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL rst_ctrl got=%h exp=0000", v); end
      bus_read(4'h8, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL rst_div got=%h exp=0000", v); end
   endtask

   task automatic test_mode0_loopback;
      logic [15:0] v;
      logic prev;
      int toggles = 0, last_t = 0, gap_bad = 0, ss_bad = 0, low_cnt = 0, irq_hi = 0;
      bit seen = 0;
      loop_en = 1'b1;
      bus_write(4'h8, 16'd1);
      bus_write(4'h2, 16'h0001);
      bus_write(4'h0, 16'h00A5);
      prev = sck;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (sck !== prev) begin
            if (toggles > 0 && n - last_t != 2) gap_bad++;
            if (ss !== 2'b10) ss_bad++;
            toggles++;
            last_t = n;
            prev = sck;
         end
         if (irq !== 1'b0) irq_hi++;
         if (ss[0] === 1'b0) begin
            low_cnt++;
            seen = 1;
         end else if (seen) break;
      end
      total++; if (toggles != 16) begin bad++; $display("FAIL m0_toggles got=%0d exp=16", toggles); end
      total++; if (gap_bad != 0)  begin bad++; $display("FAIL m0_gap got=%0d exp=0", gap_bad); end
      total++; if (ss_bad != 0)   begin bad++; $display("FAIL m0_ss got=%0d exp=0", ss_bad); end
      total++; if (low_cnt != 36) begin bad++; $display("FAIL m0_ss_low_cycles got=%0d exp=36", low_cnt); end
      total++; if (irq_hi != 0)   begin bad++; $display("FAIL m0_irq got=%0d exp=0", irq_hi); end
      bus_read(4'h4, v);
      total++; if (v !== 16'h00A5) begin bad++; $display("FAIL m0_rxdata got=%h exp=00a5", v); end
   endtask

   task automatic test_modes;
      logic [15:0] v;
      bit seen;
      loop_en = 1'b0;
      for (int m = 1; m <= 3; m++) begin
         tb_cpol = m[1];
         tb_cpha = m[0];
         slave_word = 8'h3C;
         bus_write(4'h2, {13'b0, tb_cpha, tb_cpol, 1'b1});
         repeat (2) @(negedge clk);
         total++; if (sck !== tb_cpol) begin bad++; $display("FAIL mode%0d_idle_sck got=%b exp=%b", m, sck, tb_cpol); end
         bus_write(4'h0, 16'h00C3);
         seen = 0;
         for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (ss[0] === 1'b0) seen = 1;
            else if (seen) break;
         end
         total++; if (slv_rx !== 8'hC3) begin bad++; $display("FAIL mode%0d_slave_rx got=%h exp=c3", m, slv_rx); end
         bus_read(4'h4, v);
         total++; if (v !== 16'h003C) begin bad++; $display("FAIL mode%0d_rxdata got=%h exp=003c", m, v); end
         total++; if (sck !== tb_cpol) begin bad++; $display("FAIL mode%0d_end_sck got=%b exp=%b", m, sck, tb_cpol); end
      end
   endtask

   task automatic test_hold;
      logic [15:0] v;
      logic [7:0] exp_w [4];
      logic prev, prev_ss1;
      int toggles = 0, last_t = 0, low_cnt = 0, rises = 0, rise_t = 0, ss0_bad = 0;
      exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
      loop_en = 1'b1;
      bus_write(4'h2, 16'h0028);
      for (int i = 0; i < 4; i++) bus_write(4'h0, {8'h00, exp_w[i]});
      bus_write(4'h2, 16'h0029);
      prev = sck;
      prev_ss1 = ss[1];
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (sck !== prev) begin
            toggles++;
            last_t = n;
            prev = sck;
         end
         if (ss[1] === 1'b0) low_cnt++;
         if (ss[1] === 1'b1 && prev_ss1 === 1'b0) begin
            rises++;
            rise_t = n;
         end
         if (ss[0] !== 1'b1) ss0_bad++;
         prev_ss1 = ss[1];
      end
      total++; if (rises != 1)          begin bad++; $display("FAIL hold_ss_rises got=%0d exp=1", rises); end
      total++; if (low_cnt != 144)      begin bad++; $display("FAIL hold_ss_low_cycles got=%0d exp=144", low_cnt); end
      total++; if (toggles != 64)       begin bad++; $display("FAIL hold_toggles got=%0d exp=64", toggles); end
      total++; if (rise_t - last_t != 2) begin bad++; $display("FAIL hold_ss_release got=%0d exp=2", rise_t - last_t); end
      total++; if (ss0_bad != 0)        begin bad++; $display("FAIL hold_ss0 got=%0d exp=0", ss0_bad); end
      for (int i = 0; i < 4; i++) begin
         bus_read(4'h4, v);
         total++; if (v !== {8'h00, exp_w[i]}) begin bad++; $display("FAIL hold_rx%0d got=%h exp=%h", i, v, exp_w[i]); end
      end
   endtask

   task automatic test_overflow;
      logic [15:0] v;
      loop_en = 1'b1;
      bus_write(4'h2, 16'h0000);
      for (int i = 1; i <= 5; i++) bus_write(4'h0, 16'(i));
      bus_read(4'h6, v);
      total++; if (v !== 16'h002C) begin bad++; $display("FAIL ovf_tx_status got=%h exp=002c", v); end
      bus_write(4'h2, 16'h0001);
      bus_write(4'h0, 16'h0005);
      repeat (300) @(negedge clk);
      bus_read(4'h6, v);
      total++; if (v !== 16'h0072) begin bad++; $display("FAIL ovf_rx_status got=%h exp=0072", v); end
      for (int i = 1; i <= 4; i++) begin
         bus_read(4'h4, v);
         total++; if (v !== 16'(i)) begin bad++; $display("FAIL ovf_rx%0d got=%h exp=%h", i, v, 16'(i)); end
      end
      bus_read(4'h6, v);
      total++; if (v !== 16'h006A) begin bad++; $display("FAIL ovf_drained_status got=%h exp=006a", v); end
      bus_write(4'h2, 16'h0101);
      bus_read(4'h6, v);
      total++; if (v !== 16'h000A) begin bad++; $display("FAIL ovf_cleared_status got=%h exp=000a", v); end
      bus_read(4'h2, v);
      total++; if (v !== 16'h0001) begin bad++; $display("FAIL ovf_ctrl_readback got=%h exp=0001", v); end
   endtask

   task automatic test_irq;
      logic [15:0] v;
      int irq_n = -1;
      bus_write(4'h2, 16'h0011);
      bus_write(4'h0, 16'h005A);
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (irq === 1'b1) begin
            irq_n = n;
            break;
         end
      end
      total++; if (irq_n != 38) begin bad++; $display("FAIL irq_rise_cycle got=%0d exp=38", irq_n); end
      bus_read(4'h4, v);
      total++; if (v !== 16'h005A) begin bad++; $display("FAIL irq_rxdata got=%h exp=005a", v); end
      total++; if (irq !== 1'b1)   begin bad++; $display("FAIL irq_hold_on_read got=%b exp=1", irq); end
      @(negedge clk);
      total++; if (irq !== 1'b0)   begin bad++; $display("FAIL irq_drop got=%b exp=0", irq); end
      bus_read(4'h4, v);
      total++; if (v !== 16'h0000) begin bad++; $display("FAIL irq_empty_read got=%h exp=0000", v); end
      bus_read(4'h6, v);
      total++; if (v !== 16'h000A) begin bad++; $display("FAIL irq_empty_status got=%h exp=000a", v); end
      bus_write(4'h0, 16'h0077);
      repeat (45) @(negedge clk);
      bus_read(4'h4, v);
      total++; if (v !== 16'h0077) begin bad++; $display("FAIL irq_after_empty_rx got=%h exp=0077", v); end
   endtask

   initial begin
      rst = 1'b1;
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0;
      loop_en = 1'b1; slave_miso = 1'b0;
      tb_cpol = 1'b0; tb_cpha = 1'b0; slave_word = 8'h00;
      slv_out = 8'h00; slv_rx = 8'h00;
      test_reset;
      test_mode0_loopback;
      test_modes;
      test_hold;
      test_overflow;
      test_irq;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
